// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Drives 16 chip outputs from the SPI register-file control registers.
//   Each output is forced low, forced high, or follows one shared PWM
//   waveform produced by a clock prescaler and an 8-bit period counter.
//   Outputs are registered.
//
// Optional feature macro: PWM_SYNC_UPDATE_EN
//   defined   : duty is shadowed into duty_active and only loads at the
//               period wrap, so duty updates never glitch a period.
//   undefined : the counter is compared against pwm_duty_cycle directly;
//               a duty change reaches out one clk later, mid-period.
module pwm_peripheral #(
  parameter int CLK_DIV  = 3000,
  parameter int PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int            PW        = $clog2(CLK_DIV) + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [15:0]         out_q, out_d;
  logic                period_start_q, period_start_d;
  logic                tick_s;
  logic                wrap_s;
  logic [7:0]          duty_sel_s;
  logic                pwm_sig_s;
  logic [15:0]         en_out_s;
  logic [15:0]         en_pwm_s;

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] duty_q, duty_d;
`endif

  // Prescaler and period counter next state; wrap is the last tick of a period.
  always_comb begin
    tick_s = (presc_q == PRESC_MAX);
    if (tick_s) begin
      presc_d = {PW{1'b0}};
      cnt_d   = cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
    end else begin
      presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
      cnt_d   = cnt_q;
    end
    wrap_s         = tick_s && (cnt_q == {PWM_BITS{1'b1}});
    period_start_d = wrap_s;
  end

`ifdef PWM_SYNC_UPDATE_EN
  // Duty shadow: capture the requested duty only at the period wrap.
  always_comb begin
    if (wrap_s) begin
      duty_d = pwm_duty_cycle;
    end else begin
      duty_d = duty_q;
    end
    duty_sel_s = duty_q;
  end
`else
  // Duty bypass: the waveform follows the requested duty immediately.
  always_comb begin
    duty_sel_s = pwm_duty_cycle;
  end
`endif

  // PWM waveform; full-scale duty is held high with no one-tick low gap.
  always_comb begin
    if (duty_sel_s == 8'hFF) begin
      pwm_sig_s = 1'b1;
    end else begin
      pwm_sig_s = (cnt_q < duty_sel_s);
    end
  end

  // Per-bit output mode select: low, high, or PWM.
  always_comb begin
    en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    out_d    = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      case ({en_out_s[i], en_pwm_s[i]})
        2'b10:   out_d[i] = 1'b1;
        2'b11:   out_d[i] = pwm_sig_s;
        default: out_d[i] = 1'b0;
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= {PW{1'b0}};
      cnt_q          <= {PWM_BITS{1'b0}};
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  // Duty shadow register, cleared so the first period runs at duty 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= 8'h00;
    end else begin
      duty_q <= duty_d;
    end
  end
`endif

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (CLK_DIV=1 and CLK_DIV=4) share
// the same control inputs and are compared every cycle against an
// arithmetic model based on the number of clocks since reset, plus
// directed measurements with hand-computed expectations.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out1, out4;
  logic        ps1, ps4;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(1), .PWM_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out1), .period_start(ps1));

  pwm_peripheral #(.CLK_DIV(4), .PWM_BITS(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out4), .period_start(ps4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n = clocks since reset (mod one full period). Prescaler = n % div,
  // counter = (n / div) % 256. Wrap is the clock where the counter is 255
  // on its last prescaler cycle.
  int          m_n   [2];
  logic [7:0]  m_duty[2];
  logic [15:0] m_out [2];
  logic        m_ps  [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_n[i] = 0; m_duty[i] = 8'h00; m_out[i] = 16'h0000; m_ps[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int dv, presc, cnt;
        int d;
        logic pw;
        logic [15:0] eo, ep;
        dv    = div_of(i);
        presc = m_n[i] % dv;
        cnt   = (m_n[i] / dv) % 256;
`ifdef PWM_SYNC_UPDATE_EN
        d = int'(m_duty[i]);
`else
        d = int'(duty);
`endif
        pw = (d == 255) ? 1'b1 : (cnt < d);
        eo = {eo_hi, eo_lo};
        ep = {ep_hi, ep_lo};
        m_out[i] = eo & (~ep | {16{pw}});
        m_ps[i]  = (presc == dv - 1) && (cnt == 255);
        if (m_ps[i]) m_duty[i] = duty;
        m_n[i] = (m_n[i] + 1) % (256 * dv);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_div1", out1, m_out[0]);
      check("ps_div1",  ps1,  m_ps[0]);
      check("out_div4", out4, m_out[1]);
      check("ps_div4",  ps4,  m_ps[1]);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  task automatic wait_ps(input int sel, input int max, output int waited);
    waited = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((sel == 0 && ps1) || (sel == 1 && ps4)) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      checks++; errors++;
      $display("FAIL wait_period_start: actual=timeout required=pulse within %0d clks", max);
    end
  endtask

  task automatic count_high1(input int len, output int hi);
    hi = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (out1[0]) hi++;
    end
  endtask

  task automatic measure_duty(input logic [7:0] dv, input int exp, input string nm);
    int w, hi;
    duty = dv;
    wait_ps(0, 600, w);
    repeat (2) @(negedge clk);
    count_high1(256, hi);
    check(nm, hi, exp);
  endtask

  initial begin
    int w, hi, ebad, pbad, ohi;
    rst_n = 1'b0;
    duty  = 8'h00;
    set_en(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    check("reset_out1", out1, 16'h0000);
    check("reset_ps1",  ps1,  1'b0);
    check("reset_out4", out4, 16'h0000);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Static modes
    set_en(16'h00FF, 16'h0000);
    @(negedge clk);
    check("static_high", out1, 16'h00FF);
    set_en(16'h0000, 16'h0000);
    @(negedge clk);
    check("static_low", out1, 16'h0000);

    // Duty sweep on out[0]
    set_en(16'h0001, 16'h0001);
    measure_duty(8'h00, 0,   "duty_00");
    measure_duty(8'h80, 128, "duty_80");
    measure_duty(8'hFF, 256, "duty_FF");

    // Shadow update: 0xC0 written when counter is 0x20
    duty = 8'h40;
    wait_ps(0, 600, w);
    wait_ps(0, 600, w);
    hi = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (out1[0]) hi++;
      if (k == 32) duty = 8'hC0;
    end
`ifdef PWM_SYNC_UPDATE_EN
    check("shadow_cur_period", hi, 64);
`else
    check("shadow_cur_period", hi, 192);
`endif
    count_high1(256, hi);
    check("shadow_next_period", hi, 192);

    // Duty written on the clock of the wrap is captured
    duty = 8'h80;
    wait_ps(0, 600, w);
    wait_ps(0, 600, w);
    repeat (255) @(negedge clk);
    duty = 8'h30;
    @(negedge clk);
    check("wrap_edge_ps", ps1, 1'b1);
    count_high1(256, hi);
    check("wrap_edge_capture", hi, 48);

    // Prescaler CLK_DIV=4
    duty = 8'h01;
    wait_ps(1, 2100, w);
    wait_ps(1, 2100, w);
    check("div4_interval", w, 1024);
    hi = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (out4[0]) hi++;
    end
    check("div4_high", hi, 4);

    // Mixed modes
    set_en(16'hFFFF, 16'hAAAA);
    duty = 8'h10;
    wait_ps(0, 600, w);
    repeat (2) @(negedge clk);
    ebad = 0; pbad = 0; ohi = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if ((out1 & 16'h5555) != 16'h5555) ebad++;
      if ((out1 & 16'hAAAA) != 16'h0000 && (out1 & 16'hAAAA) != 16'hAAAA) pbad++;
      if (out1[1]) ohi++;
    end
    check("mixed_even_high", ebad, 0);
    check("mixed_odd_phase", pbad, 0);
    check("mixed_odd_count", ohi, 16);

    // Asynchronous reset mid-period
    set_en(16'hFFFF, 16'h0000);
    repeat (2) @(negedge clk);
    check("pre_reset_out", out1, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out1", out1, 16'h0000);
    check("async_reset_ps1",  ps1,  1'b0);
    check("async_reset_out4", out4, 16'h0000);
    set_en(16'h0001, 16'h0001);
    duty = 8'h80;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps(0, 600, w);
    check("restart_first_wrap", w, 256);

    // Randomised run checked by the model
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) set_en(16'($urandom), 16'($urandom));
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
